stopwatch_core: RTL
===================

// Module: stopwatch_core
// PURPOSE
//  Parametrised MM:SS BCD stopwatch/timer core; next generation of the lab timer counter.
//  Single clock domain: 1 Hz and adjust-rate strobes arrive as one-cycle enables, not as clocks.
//  Adds count-down mode, an expiry flag, a roll-over pulse, a synchronous clear and an optional lap capture.
//  Sits between the clock-divider/debounce front end and the 7-segment display mux.
// PARAMETERS
//  MAX_MIN   59  highest minute value before wrap (legal 1..99); digits stay BCD
//  MAX_SEC   59  highest second value before wrap (legal 9..59)
// PORTS
//  clk       in   1  system clock; all state changes on its rising edge
//  reset     in   1  asynchronous, active-low reset
//  tick      in   1  count enable, 1 Hz, one clk cycle wide
//  tick_adj  in   1  adjust-rate enable (e.g. 2 Hz), one clk cycle wide
//  pause_p   in   1  debounced pause pulse, one cycle; toggles run state
//  clear_p   in   1  debounced clear pulse, one cycle; zeroes count
//  adjust    in   1  1 = adjust mode (normal counting suspended)
//  select    in   1  adjust field: 1 = seconds, 0 = minutes
//  dir       in   1  0 = count up, 1 = count down
//  lap_p     in   1  lap capture pulse (ignored unless STOPWATCH_LAP_EN)
//  min1,min0 out  4  BCD minute tens/units
//  sec1,sec0 out  4  BCD second tens/units
//  running   out  1  1 = counting enabled
//  done      out  1  down mode reached 00:00 (sticky)
//  wrap      out  1  one-cycle pulse on up-mode roll-over MAX_MIN:MAX_SEC -> 00:00
//  lap_min1,lap_min0,lap_sec1,lap_sec0  out 4  captured lap value
//  lap_valid out  1  lap registers hold a capture
// BEHAVIOUR
//  - Reset (reset=0): all digits 0, running=0, done=0, wrap=0, lap_* = 0, lap_valid=0.
//  - All outputs registered; an event sampled in cycle N is visible after edge N+1.
//  - Priority per cycle: clear_p > adjust > counting. pause_p is evaluated independently.
//  - pause_p: running <= ~running. Concurrent tick uses the pre-toggle value of running.
//  - clear_p: digits -> 00:00, done -> 0. running is unchanged. Any tick in the same cycle is discarded.
//  - Counting happens only when tick & running & ~adjust & ~clear_p.
//  - Up count: sec+1; from MAX_SEC -> 0 with carry, min+1.
//    At MAX_MIN:MAX_SEC -> 00:00 and wrap=1 for exactly one cycle.
//  - Down count: sec-1; from 0 -> MAX_SEC with borrow, min-1.
//    Tick at 01 seconds reaching 00:00 (or tick while already at 00:00): count holds 00:00,
//    done <= 1, running <= 0 (auto-stop). No underflow ever.
//  - done clears on reset, clear_p, or any adjust increment.
//  - Adjust (adjust=1): counting is frozen. On tick_adj, the field chosen by select increments by 1.
//    Seconds wrap MAX_SEC -> 0 and minutes wrap MAX_MIN -> 0. No carry between fields.
//    Works whether running or not. running is not modified.
//  - Changing dir mid-count takes effect on the next tick. The count value is kept.
//  - BCD arithmetic only: the units digit never exceeds 9; the tens digit is bounded by the MAX_* tens digit.
//  - Asynchronous reset mid-count aborts everything immediately. No pending state survives.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//    - lap_p copies the four current digits (pre-update value, same cycle) into the lap_* registers
//      and sets lap_valid=1.
//    - clear_p clears lap_* and lap_valid.
//    - lap_p concurrent with clear_p: the clear wins.
//  STOPWATCH_LAP_EN undefined:
//    - lap_p is ignored; lap_* and lap_valid are tied to 0.
//    - No lap registers are synthesised.
// TESTING
//  1. Reset, pause_p, 61 ticks up -> 01:01, running=1.
//  2. Preload 59:59 via adjust, up, 1 tick -> 00:00, wrap high exactly 1 cycle.
//  3. Load 00:02, dir=1, run, 3 ticks -> 00:01, 00:00 with done=1 and running=0; 4th tick -> stays 00:00.
//  4. adjust=1, select=0 at min 59, tick_adj -> min 00, sec unchanged; ticks during adjust ignored.
//  5. Same cycle: tick + pause_p while running at 00:05 -> 00:06 and running=0.
//     Then clear_p + tick -> 00:00, done=0.
//  6. (LAP_EN) At 00:07, lap_p -> lap=00:07, lap_valid=1, live count continues.
//     Then reset low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch/timer core with up/down count, expiry, roll-over pulse and adjust.
// Optional lap capture registers are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       tick_adj,
  input  logic       pause_p,
  input  logic       clear_p,
  input  logic       adjust,
  input  logic       select,
  input  logic       dir,
  input  logic       lap_p,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       running,
  output logic       done,
  output logic       wrap,
  output logic [3:0] lap_min1,
  output logic [3:0] lap_min0,
  output logic [3:0] lap_sec1,
  output logic [3:0] lap_sec0,
  output logic       lap_valid
);

  localparam logic [7:0] MMAX = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] SMAX = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};

  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_running;
  logic       r_done;
  logic       r_wrap;

  logic [7:0] w_min_n;
  logic [7:0] w_sec_n;
  logic       w_run_n;
  logic       w_done_n;
  logic       w_wrap_n;
  logic       w_cnt;
  logic       w_clr;
  logic       w_adj;
  logic       w_up;
  logic       w_dn;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] vmax);
    if (v == vmax)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                         input logic [7:0] vmax);
    if (v == 8'h00)
      return vmax;
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // One-hot qualified actions; clear beats adjust beats counting.
  assign w_cnt = tick & r_running & ~adjust & ~clear_p;
  assign w_clr = clear_p;
  assign w_adj = ~clear_p & adjust & tick_adj;
  assign w_up  = w_cnt & ~dir;
  assign w_dn  = w_cnt & dir;

  always_comb begin
    w_min_n  = r_min;
    w_sec_n  = r_sec;
    w_done_n = r_done;
    w_wrap_n = 1'b0;
    w_run_n  = pause_p ? ~r_running : r_running;
    unique case (1'b1)
      w_clr: begin
        w_min_n  = 8'h00;
        w_sec_n  = 8'h00;
        w_done_n = 1'b0;
      end
      w_adj: begin
        if (select)
          w_sec_n = bcd_inc(r_sec, SMAX);
        else
          w_min_n = bcd_inc(r_min, MMAX);
        w_done_n = 1'b0;
      end
      w_up: begin
        w_sec_n = bcd_inc(r_sec, SMAX);
        if (r_sec == SMAX) begin
          w_min_n  = bcd_inc(r_min, MMAX);
          w_wrap_n = (r_min == MMAX);
        end
      end
      w_dn: begin
        // Reaching or sitting at 00:00 expires and stops.
        if (r_min == 8'h00 && r_sec <= 8'h01) begin
          w_min_n  = 8'h00;
          w_sec_n  = 8'h00;
          w_done_n = 1'b1;
          w_run_n  = 1'b0;
        end else begin
          w_sec_n = bcd_dec(r_sec, SMAX);
          if (r_sec == 8'h00)
            w_min_n = bcd_dec(r_min, MMAX);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_min     <= 8'h00;
      r_sec     <= 8'h00;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_min     <= w_min_n;
      r_sec     <= w_sec_n;
      r_running <= w_run_n;
      r_done    <= w_done_n;
      r_wrap    <= w_wrap_n;
    end
  end

  assign min1    = r_min[7:4];
  assign min0    = r_min[3:0];
  assign sec1    = r_sec[7:4];
  assign sec0    = r_sec[3:0];
  assign running = r_running;
  assign done    = r_done;
  assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
  logic [15:0] r_lap;
  logic        r_lap_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lap       <= 16'h0000;
      r_lap_valid <= 1'b0;
    end else if (clear_p) begin
      r_lap       <= 16'h0000;
      r_lap_valid <= 1'b0;
    end else if (lap_p) begin
      r_lap       <= {r_min, r_sec};
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_min1  = r_lap[15:12];
  assign lap_min0  = r_lap[11:8];
  assign lap_sec1  = r_lap[7:4];
  assign lap_sec0  = r_lap[3:0];
  assign lap_valid = r_lap_valid;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap_p;
  assign lap_min1     = 4'd0;
  assign lap_min0     = 4'd0;
  assign lap_sec1     = 4'd0;
  assign lap_sec0     = 4'd0;
  assign lap_valid    = 1'b0;
`endif

endmodule
